// File: rtl/fifo_arb_pkg.sv
// Shared types and default parameters for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  localparam int ARB_NUM_REQ    = 4;
  localparam int ARB_DATA_WIDTH = 32;
  localparam int ARB_MAX_BURST  = 4;
  localparam int ARB_STATS_W    = 32;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: first valid requester at or after rr_ptr, wrapping.
module rr_priority_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = ARB_NUM_REQ,
  parameter int REQ_IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [REQ_IDX_W-1:0] rr_ptr,
  output logic                 found,
  output logic [REQ_IDX_W-1:0] winner
);

  always_comb begin
    int sum;
    logic [REQ_IDX_W-1:0] idx;
    sum    = 0;
    idx    = '0;
    found  = 1'b0;
    winner = '0;
    // Walk from farthest to nearest so the nearest valid requester is written last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = int'(rr_ptr) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = REQ_IDX_W'(sum);
      if (req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin, burst-limited arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional per-requester beat counters are built when ARB_STATS_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ARB_IDLE  | no owner; pick next requester from rr_ptr, grant next cycle
// ARB_GRANT | owner grant_idx streams beats until burst limit or withdraw
module fifo_rr_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = ARB_NUM_REQ,
  parameter int DATA_WIDTH = ARB_DATA_WIDTH,
  parameter int MAX_BURST  = ARB_MAX_BURST,
  localparam int REQ_IDX_W   = $clog2(NUM_REQ),
  localparam int BURST_CNT_W = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_w_req,
  output logic [DATA_WIDTH-1:0]         fifo_w_data,
  input  logic                          fifo_w_stall,
  output logic [NUM_REQ-1:0]            grant_onehot,
  output logic [REQ_IDX_W-1:0]          grant_idx,
  output logic                          busy
`ifdef ARB_STATS_EN
  ,
  output logic [NUM_REQ*ARB_STATS_W-1:0] beat_count
`endif
);

  arb_state_t             state;
  logic [REQ_IDX_W-1:0]   rr_ptr;
  logic [BURST_CNT_W-1:0] burst_cnt;
  logic                   pick_found;
  logic [REQ_IDX_W-1:0]   pick_winner;
  logic                   owner_valid;
  logic                   beat;
  logic                   last_beat;
  logic                   release_grant;

  rr_priority_picker #(
    .NUM_REQ   (NUM_REQ),
    .REQ_IDX_W (REQ_IDX_W)
  ) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .found     (pick_found),
    .winner    (pick_winner)
  );

  assign busy          = (state == ARB_GRANT);
  assign owner_valid   = req_valid[grant_idx];
  assign beat          = busy && owner_valid && !fifo_w_stall;
  assign last_beat     = beat && (burst_cnt == BURST_CNT_W'(MAX_BURST - 1));
  // A withdrawn owner releases even while stalled; no beat is possible then.
  assign release_grant = busy && (last_beat || !owner_valid);
  assign req_ready     = (busy && !fifo_w_stall) ? grant_onehot : '0;
  assign fifo_w_req    = beat;

  always_comb begin
    fifo_w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (busy && (grant_idx == REQ_IDX_W'(i))) fifo_w_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ARB_IDLE;
      rr_ptr       <= '0;
      grant_idx    <= '0;
      grant_onehot <= '0;
      burst_cnt    <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            state        <= ARB_GRANT;
            grant_idx    <= pick_winner;
            grant_onehot <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_winner;
            burst_cnt    <= '0;
          end
        end
        ARB_GRANT: begin
          if (release_grant) begin
            state        <= ARB_IDLE;
            grant_idx    <= '0;
            grant_onehot <= '0;
            burst_cnt    <= '0;
            rr_ptr       <= (grant_idx == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          end else if (beat) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_count <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (beat && (grant_idx == REQ_IDX_W'(i)))
          beat_count[i*ARB_STATS_W +: ARB_STATS_W] <= beat_count[i*ARB_STATS_W +: ARB_STATS_W] + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// Self-checking bench: behavioural arbitration model plus directed scenarios and random traffic.
module tb_fifo_rr_write_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int MB = 4;
  localparam int IW = 2;

  logic              clk;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              fifo_w_req;
  logic [DW-1:0]     fifo_w_data;
  logic              fifo_w_stall;
  logic [NR-1:0]     grant_onehot;
  logic [IW-1:0]     grant_idx;
  logic              busy;
`ifdef ARB_STATS_EN
  logic [NR*32-1:0]  beat_count;
`endif

  int checks = 0;
  int errors = 0;

  fifo_rr_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_w_req   (fifo_w_req),
    .fifo_w_data  (fifo_w_data),
    .fifo_w_stall (fifo_w_stall),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .busy         (busy)
`ifdef ARB_STATS_EN
    ,
    .beat_count   (beat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Producer state and bench controls
  int         seq[NR];
  int         remaining[NR];
  bit         rand_mode;
  bit         stall_force;
  logic [NR-1:0] acc;

  // Reference model state
  int m_owner;
  int m_cnt;
  int m_ptr;
  int m_beats[NR];

  int rec_busy[$];
  int rec_idx[$];
  int rec_wreq[$];
  int rec_rdy0[$];

  function automatic logic [31:0] mk_data(int i, int s);
    return 32'((i << 24) | (s & 32'h00FF_FFFF));
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_rec();
    rec_busy.delete();
    rec_idx.delete();
    rec_wreq.delete();
    rec_rdy0.delete();
  endtask

  task automatic settle();
    for (int i = 0; i < NR; i++) remaining[i] = 0;
    stall_force = 1'b0;
    rand_mode   = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  // Producers: advance on an accepted beat, then present the next beat.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        seq[i]++;
        if (remaining[i] > 0) remaining[i]--;
      end
      req_valid[i] = rand_mode ? ($urandom_range(0, 99) < 70) : (remaining[i] > 0);
      req_data[i*DW +: DW] = mk_data(i, seq[i]);
    end
    fifo_w_stall = rand_mode ? ($urandom_range(0, 99) < 25) : stall_force;
  end

  // Compare process: check every cycle against the model, then advance the model.
  always @(negedge clk) begin
    bit            e_busy;
    int            e_idx;
    logic [NR-1:0] e_oh;
    logic [NR-1:0] e_ready;
    bit            e_wreq;
    bit            got;
    int            j;
    if (reset) begin
      m_owner = -1;
      m_cnt   = 0;
      m_ptr   = 0;
      acc     = '0;
      for (int i = 0; i < NR; i++) m_beats[i] = 0;
    end else begin
      e_busy  = (m_owner >= 0);
      e_idx   = e_busy ? m_owner : 0;
      e_oh    = e_busy ? NR'(1 << m_owner) : '0;
      e_ready = (e_busy && !fifo_w_stall) ? e_oh : '0;
      e_wreq  = e_busy && req_valid[e_idx] && !fifo_w_stall;
      chk("busy", busy, e_busy);
      chk("grant_idx", grant_idx, e_idx);
      chk("grant_onehot", grant_onehot, e_oh);
      chk("req_ready", req_ready, e_ready);
      chk("fifo_w_req", fifo_w_req, e_wreq);
      if (e_wreq) chk("fifo_w_data", fifo_w_data, mk_data(m_owner, seq[m_owner]));
      rec_busy.push_back(int'(busy));
      rec_idx.push_back(int'(grant_idx));
      rec_wreq.push_back(int'(fifo_w_req));
      rec_rdy0.push_back(int'(req_ready[0]));
      acc = req_valid & req_ready;
      if (e_wreq) m_beats[m_owner]++;
      if (m_owner < 0) begin
        got = 1'b0;
        for (int k = 0; k < NR; k++) begin
          j = (m_ptr + k) % NR;
          if (!got && req_valid[j]) begin
            got     = 1'b1;
            m_owner = j;
            m_cnt   = 0;
          end
        end
      end else if (!req_valid[m_owner]) begin
        m_ptr   = (m_owner + 1) % NR;
        m_owner = -1;
      end else if (!fifo_w_stall) begin
        m_cnt++;
        if (m_cnt == MB) begin
          m_ptr   = (m_owner + 1) % NR;
          m_owner = -1;
        end
      end
    end
  end

  initial begin
    int owners[$];
    int s2_busy[15] = '{0,1,1,1,1,0,1,1,1,1,0,1,1,1,0};
    int s2_wreq[15] = '{0,1,1,1,1,0,1,1,1,1,0,1,1,0,0};
    int s3_busy[9]  = '{0,1,1,1,1,1,1,1,0};
    int s3_wreq[9]  = '{0,1,1,0,0,0,1,1,0};
    int s4_busy[10] = '{0,1,1,1,0,1,1,1,1,0};
    int s4_idx[10]  = '{0,1,1,1,0,3,3,3,3,0};
    int s4_wreq[10] = '{0,1,1,0,0,1,1,1,1,0};

    reset        = 1'b1;
    req_valid    = '0;
    req_data     = '0;
    fifo_w_stall = 1'b0;
    rand_mode    = 1'b0;
    stall_force  = 1'b0;
    acc          = '0;
    for (int i = 0; i < NR; i++) begin
      seq[i]       = 0;
      remaining[i] = 0;
    end
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_grant_onehot", grant_onehot, 0);
    chk("rst_grant_idx", grant_idx, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_fifo_w_req", fifo_w_req, 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    repeat (2) @(posedge clk);

    // 1: all four valid continuously
    clear_rec();
    for (int i = 0; i < NR; i++) remaining[i] = 1000;
    repeat (20) @(posedge clk);
    for (int i = 0; i < NR; i++) remaining[i] = 0;
    chk("s1_len", rec_busy.size(), 20);
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("s1_busy[%0d]", k), rec_busy[k], (k % 5 != 0) ? 1 : 0);
      chk($sformatf("s1_idx[%0d]", k), rec_idx[k], (k % 5 != 0) ? k / 5 : 0);
      if (rec_wreq[k] != 0) owners.push_back(rec_idx[k]);
    end
    chk("s1_beats", owners.size(), 16);
    for (int b = 0; b < owners.size() && b < 16; b++)
      chk($sformatf("s1_owner[%0d]", b), owners[b], b / 4);
    @(posedge clk);
    #2;
`ifdef ARB_STATS_EN
    for (int i = 0; i < NR; i++) chk($sformatf("s1_beat_count[%0d]", i), beat_count[i*32 +: 32], 4);
`endif
    settle();

    // 2: only req2, ten beats -> bursts 4,4,2
    clear_rec();
    remaining[2] = 10;
    repeat (15) @(posedge clk);
    for (int k = 0; k < 15; k++) begin
      chk($sformatf("s2_busy[%0d]", k), rec_busy[k], s2_busy[k]);
      chk($sformatf("s2_wreq[%0d]", k), rec_wreq[k], s2_wreq[k]);
      if (rec_busy[k] != 0) chk($sformatf("s2_idx[%0d]", k), rec_idx[k], 2);
    end
    settle();

    // 3: stall three cycles after second beat of req0
    clear_rec();
    remaining[0] = 4;
    repeat (3) @(posedge clk);
    stall_force = 1'b1;
    repeat (3) @(posedge clk);
    stall_force = 1'b0;
    repeat (3) @(posedge clk);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("s3_busy[%0d]", k), rec_busy[k], s3_busy[k]);
      chk($sformatf("s3_wreq[%0d]", k), rec_wreq[k], s3_wreq[k]);
      chk($sformatf("s3_ready0[%0d]", k), rec_rdy0[k], s3_wreq[k]);
    end
    settle();

    // 4: req1 withdraws after two beats, req3 follows
    clear_rec();
    remaining[1] = 2;
    remaining[3] = 4;
    repeat (10) @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("s4_busy[%0d]", k), rec_busy[k], s4_busy[k]);
      chk($sformatf("s4_idx[%0d]", k), rec_idx[k], s4_idx[k]);
      chk($sformatf("s4_wreq[%0d]", k), rec_wreq[k], s4_wreq[k]);
    end
    settle();

    // 5: reset in the middle of a grant, rr_ptr restarts at 0
    remaining[2] = 100;
    repeat (7) @(posedge clk);
    #2 chk("s5_pre_busy", busy, 1);
    #1 reset = 1'b1;
    #1;
    chk("s5_busy", busy, 0);
    chk("s5_grant_onehot", grant_onehot, 0);
    chk("s5_grant_idx", grant_idx, 0);
    chk("s5_req_ready", req_ready, 0);
    chk("s5_fifo_w_req", fifo_w_req, 0);
    chk("s5_fifo_w_data", fifo_w_data, 0);
`ifdef ARB_STATS_EN
    chk("s5_beat_count", beat_count, 0);
`endif
    remaining[2] = 0;
    remaining[1] = 3;
    remaining[3] = 3;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    clear_rec();
    repeat (6) @(posedge clk);
    chk("s5_post_busy0", rec_busy[0], 0);
    chk("s5_post_busy1", rec_busy[1], 1);
    chk("s5_post_idx1", rec_idx[1], 1);
    repeat (12) @(posedge clk);
    settle();

    // Random traffic with random stalls and withdrawals
    rand_mode = 1'b1;
    repeat (3000) @(posedge clk);
    settle();
`ifdef ARB_STATS_EN
    for (int i = 0; i < NR; i++) chk($sformatf("rand_beat_count[%0d]", i), beat_count[i*32 +: 32], m_beats[i]);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
